// File: rtl/move_legality_checker.sv
// Move legality checker: bounds-checks a candidate tile, reads its maze code, reports legality/score/end-of-game.
// Optional illegal-move counter compiled in with MOVE_LEGALITY_ILLEGAL_COUNT_EN; otherwise illegalCount is tied to 0.
module move_legality_checker #(
   parameter int GRID_W = 20,
   parameter int GRID_H = 15,
   parameter int RD_LAT = 1
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       externalReset,
   input  logic       checkReq,
   input  logic [4:0] changedX,
   input  logic [4:0] changedY,
   output logic [8:0] mazeAddr,
   input  logic [2:0] mazeData,
   output logic       doneLegal,
   output logic       isLegal,
   output logic       scorePlusFive,
   output logic       scoreMinusFive,
   output logic       gameWon,
   output logic       gameOver,
   output logic       busy,
   output logic [7:0] illegalCount
);

   typedef enum logic [2:0] {IDLE, BOUNDS, READ, WAIT, DECIDE} state_t;

   localparam logic [31:0] GW        = 32'(GRID_W);
   localparam logic [31:0] GH        = 32'(GRID_H);
   localparam logic [1:0]  WAIT_LAST = 2'(RD_LAT - 1);

   state_t     state;
   logic [4:0] x_q;
   logic [4:0] y_q;
   logic [1:0] wait_cnt;

   logic       out_of_bounds;
   logic       finish;
   logic       accept;
   logic [2:0] tile;
   logic       tile_legal;
   logic [8:0] addr_calc;

   // Coordinates of 0-1 wrap to 31 and are caught here as out of bounds.
   assign out_of_bounds = ({27'd0, x_q} >= GW) || ({27'd0, y_q} >= GH);
   assign addr_calc     = 9'(y_q) * 9'(GRID_W) + 9'(x_q);
   assign accept        = checkReq && !busy && !gameWon && !gameOver;

   // A check completes either straight from BOUNDS (forced wall) or in the last WAIT cycle.
   assign finish     = ((state == BOUNDS) && out_of_bounds) ||
                       ((state == WAIT) && (wait_cnt == WAIT_LAST));
   assign tile       = (state == BOUNDS) ? 3'd1 : mazeData;
   assign tile_legal = (tile != 3'd1) && (tile < 3'd6);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         x_q            <= 5'd0;
         y_q            <= 5'd0;
         wait_cnt       <= 2'd0;
         mazeAddr       <= 9'd0;
         doneLegal      <= 1'b0;
         isLegal        <= 1'b0;
         scorePlusFive  <= 1'b0;
         scoreMinusFive <= 1'b0;
         gameWon        <= 1'b0;
         gameOver       <= 1'b0;
         busy           <= 1'b0;
      end else if (externalReset) begin
         state          <= IDLE;
         x_q            <= 5'd0;
         y_q            <= 5'd0;
         wait_cnt       <= 2'd0;
         mazeAddr       <= 9'd0;
         doneLegal      <= 1'b0;
         isLegal        <= 1'b0;
         scorePlusFive  <= 1'b0;
         scoreMinusFive <= 1'b0;
         gameWon        <= 1'b0;
         gameOver       <= 1'b0;
         busy           <= 1'b0;
      end else begin
         doneLegal <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  x_q   <= changedX;
                  y_q   <= changedY;
                  busy  <= 1'b1;
                  state <= BOUNDS;
               end
            end
            BOUNDS: begin
               if (out_of_bounds) begin
                  state <= DECIDE;
               end else begin
                  mazeAddr <= addr_calc;
                  state    <= READ;
               end
            end
            READ: begin
               wait_cnt <= 2'd0;
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == WAIT_LAST) state <= DECIDE;
               else                       wait_cnt <= wait_cnt + 2'd1;
            end
            DECIDE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Results land together with doneLegal so they are valid in the DECIDE cycle.
         if (finish) begin
            doneLegal      <= 1'b1;
            isLegal        <= tile_legal;
            scorePlusFive  <= (tile == 3'd3);
            scoreMinusFive <= (tile == 3'd4);
            if (tile == 3'd2) gameWon  <= 1'b1;
            if (tile == 3'd5) gameOver <= 1'b1;
         end
      end
   end

`ifdef MOVE_LEGALITY_ILLEGAL_COUNT_EN
   logic [7:0] illegal_cnt;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         illegal_cnt <= 8'd0;
      else if (externalReset)
         illegal_cnt <= 8'd0;
      else if (finish && !tile_legal && (illegal_cnt != 8'hFF))
         illegal_cnt <= illegal_cnt + 8'd1;
   end

   assign illegalCount = illegal_cnt;
`else
   assign illegalCount = 8'd0;
`endif

endmodule
